// File: rtl/adbg_jtag_tap.sv
// adbg_jtag_tap: IEEE 1149.1 TAP controller with IDCODE/BYPASS registers feeding the advanced debug interface.
module adbg_jtag_tap #(
   parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
   parameter int IR_LEN = 4,
   parameter logic [IR_LEN-1:0] IDCODE_INSTR = 4'b0010,
   parameter logic [IR_LEN-1:0] DEBUG_INSTR = 4'b1000,
   parameter logic [IR_LEN-1:0] BYPASS_INSTR = 4'b1111
) (
   input  logic tck_i,
   input  logic trstn_i,
   input  logic tms_i,
   input  logic tdi_i,
   input  logic debug_tdo_i,
   output logic tdo_o,
   output logic tdo_oe_o,
   output logic test_logic_reset_o,
   output logic run_test_idle_o,
   output logic capture_dr_o,
   output logic shift_dr_o,
   output logic pause_dr_o,
   output logic update_dr_o,
   output logic debug_select_o
);
   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
   } state_e;
   localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);
   state_e state_q, state_d;
   logic [IR_LEN-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
   logic [31:0] idcode_q, idcode_d;
   logic bypass_q, bypass_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
   logic sel_idcode, sel_debug, sel_bypass, dr_tdo;
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:    state_d = tms_i ? TLR    : RTI;
         RTI:    state_d = tms_i ? SEL_DR : RTI;
         SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
         PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
         EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms_i ? SEL_DR : RTI;
         SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
         CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
         PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
         EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms_i ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end
   // DR selection follows only the latched IR, so it cannot move during a DR scan
   assign sel_idcode = ir_q == IDCODE_INSTR;
   assign sel_debug  = ir_q == DEBUG_INSTR;
   assign sel_bypass = !sel_idcode && !sel_debug;
   assign dr_tdo     = sel_idcode ? idcode_q[0] : sel_debug ? debug_tdo_i : bypass_q;
   always_comb begin
      ir_shift_d = state_q == CAP_IR ? IR_CAPTURE : state_q == SH_IR ? {tdi_i, ir_shift_q[IR_LEN-1:1]} : ir_shift_q;
      idcode_d   = !sel_idcode ? idcode_q : state_q == CAP_DR ? IDCODE_VALUE : state_q == SH_DR ? {tdi_i, idcode_q[31:1]} : idcode_q;
      bypass_d   = !sel_bypass ? bypass_q : state_q == CAP_DR ? 1'b0 : state_q == SH_DR ? tdi_i : bypass_q;
      ir_d       = state_q == TLR ? IDCODE_INSTR : state_q == UPD_IR ? ir_shift_q : ir_q;
      tdo_d      = state_q == SH_IR ? ir_shift_q[0] : state_q == SH_DR ? dr_tdo : tdo_q;
      tdo_oe_d   = state_q == SH_IR || state_q == SH_DR;
   end
   always_ff @(posedge tck_i or negedge trstn_i) begin
      if (!trstn_i) begin
         state_q    <= TLR;
         ir_shift_q <= IR_CAPTURE;
         idcode_q   <= IDCODE_VALUE;
         bypass_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_shift_q <= ir_shift_d;
         idcode_q   <= idcode_d;
         bypass_q   <= bypass_d;
      end
   end
   always_ff @(negedge tck_i or negedge trstn_i) begin
      if (!trstn_i) begin
         ir_q     <= IDCODE_INSTR;
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         tdo_q    <= tdo_d;
         tdo_oe_q <= tdo_oe_d;
      end
   end
   assign tdo_o              = tdo_q;
   assign tdo_oe_o           = tdo_oe_q;
   assign test_logic_reset_o = state_q == TLR;
   assign run_test_idle_o    = state_q == RTI;
   assign capture_dr_o       = state_q == CAP_DR;
   assign shift_dr_o         = state_q == SH_DR;
   assign pause_dr_o         = state_q == PA_DR;
   assign update_dr_o        = state_q == UPD_DR;
   assign debug_select_o     = sel_debug;
endmodule

// File: tb/tb_adbg_jtag_tap.sv
// tb_adbg_jtag_tap: randomized TAP scans checked against a table/queue model of the TAP.
module tb_adbg_jtag_tap;
   localparam logic [31:0] IDV = 32'h249511C3;
   logic tck = 1'b0;
   logic trstn_i, tms_i, tdi_i, debug_tdo_i;
   logic tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o, capture_dr_o;
   logic shift_dr_o, pause_dr_o, update_dr_o, debug_select_o;
   int checks = 0, failures = 0;
   int st;
   logic [3:0] m_ir;
   logic m_tdo, m_oe;
   logic dr_q[$];
   logic irq[$];
   logic obs[$];
   int n_cap, n_sh, n_upd;
   // state index order: TLR RTI SEL_DR CAP_DR SH_DR EX1_DR PA_DR EX2_DR UPD_DR SEL_IR CAP_IR SH_IR EX1_IR PA_IR EX2_IR UPD_IR
   int n0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int n1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

   always #5 tck = ~tck;

   adbg_jtag_tap dut (
      .tck_i(tck), .trstn_i(trstn_i), .tms_i(tms_i), .tdi_i(tdi_i), .debug_tdo_i(debug_tdo_i),
      .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .test_logic_reset_o(test_logic_reset_o),
      .run_test_idle_o(run_test_idle_o), .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o),
      .pause_dr_o(pause_dr_o), .update_dr_o(update_dr_o), .debug_select_o(debug_select_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_state();
      chk("test_logic_reset", 64'(test_logic_reset_o), 64'(st == 0));
      chk("run_test_idle", 64'(run_test_idle_o), 64'(st == 1));
      chk("capture_dr", 64'(capture_dr_o), 64'(st == 3));
      chk("shift_dr", 64'(shift_dr_o), 64'(st == 4));
      chk("pause_dr", 64'(pause_dr_o), 64'(st == 6));
      chk("update_dr", 64'(update_dr_o), 64'(st == 8));
   endtask

   task automatic chk_out();
      chk("tdo", 64'(tdo_o), 64'(m_tdo));
      chk("tdo_oe", 64'(tdo_oe_o), 64'(m_oe));
      chk("debug_select", 64'(debug_select_o), 64'(m_ir == 4'b1000));
      if (tdo_oe_o === 1'b1) obs.push_back(tdo_o);
   endtask

   task automatic model_reset();
      st = 0;
      m_ir = 4'b0010;
      m_tdo = 1'b0;
      m_oe = 1'b0;
      dr_q.delete();
      irq = '{1'b1, 1'b0, 1'b1, 1'b0};
   endtask

   task automatic tick(input logic tms, input logic tdi, input logic dtdo);
      tms_i = tms;
      tdi_i = tdi;
      debug_tdo_i = dtdo;
      @(posedge tck);
      if (st == 3) begin
         if (m_ir == 4'b0010) begin
            dr_q.delete();
            for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
         end else if (m_ir != 4'b1000) dr_q = '{1'b0};
      end else if (st == 4 && m_ir != 4'b1000) begin
         void'(dr_q.pop_front());
         dr_q.push_back(tdi);
      end
      if (st == 10) irq = '{1'b1, 1'b0, 1'b1, 1'b0};
      else if (st == 11) begin
         void'(irq.pop_front());
         irq.push_back(tdi);
      end
      st = tms ? n1[st] : n0[st];
      #1 chk_state();
      n_cap += int'(capture_dr_o);
      n_sh += int'(shift_dr_o);
      n_upd += int'(update_dr_o);
      @(negedge tck);
      if (st == 15) m_ir = {irq[3], irq[2], irq[1], irq[0]};
      else if (st == 0) m_ir = 4'b0010;
      m_oe = (st == 4 || st == 11);
      if (st == 11) m_tdo = irq[0];
      else if (st == 4) m_tdo = (m_ir == 4'b1000) ? dtdo : dr_q[0];
      #1 chk_out();
   endtask

   task automatic pulse_reset();
      @(posedge tck);
      #2 trstn_i = 1'b0;
      model_reset();
      #1 chk_state();
      chk_out();
      @(negedge tck);
      #2 trstn_i = 1'b1;
   endtask

   task automatic goto_rti();
      repeat (5) tick(1'b1, 1'($urandom), 1'($urandom));
      chk("five_tms_to_tlr", 64'(test_logic_reset_o), 64'd1);
      tick(1'b0, 1'($urandom), 1'($urandom));
   endtask

   task automatic ir_scan(input int n, input logic [15:0] v);
      obs.delete();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick(i == n - 1, v[i], 1'($urandom));
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic dr_scan(input int n, input logic [63:0] bits, input logic [63:0] dbits);
      obs.delete();
      n_cap = 0;
      n_sh = 0;
      n_upd = 0;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, dbits[0]);
      for (int i = 0; i < n; i++) tick(i == n - 1, bits[i], dbits[i + 1]);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [63:0] obs_vec();
      logic [63:0] v = '0;
      for (int i = 0; i < obs.size() && i < 64; i++) v[i] = obs[i];
      return v;
   endfunction

   initial begin
      logic [63:0] v;
      logic [3:0] op;
      trstn_i = 1'b0;
      tms_i = 1'b1;
      tdi_i = 1'b0;
      debug_tdo_i = 1'b0;
      model_reset();
      #2 chk_state();
      chk_out();
      @(negedge tck);
      #2 trstn_i = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      chk("rti_after_release", 64'(run_test_idle_o), 64'd1);
      chk("debug_select_after_reset", 64'(debug_select_o), 64'd0);

      dr_scan(32, 64'd0, 64'd0);
      v = obs_vec();
      chk("idcode_value", v[31:0], 64'h249511C3);
      chk("idcode_oe_count", obs.size(), 64'd32);

      dr_scan(40, 64'hFF, 64'd0);
      v = obs_vec();
      chk("idcode_overlength", v[39:32], 64'hFF);

      ir_scan(4, 16'b1000);
      v = obs_vec();
      chk("ir_capture_bits", v[3:0], 64'b0101);
      chk("debug_select_set", 64'(debug_select_o), 64'd1);

      dr_scan(10, 64'h2A5, 64'h5B3);
      v = obs_vec();
      chk("debug_tdo_mirror", v[9:0], 64'h1B3);
      chk("debug_capture_cnt", n_cap, 64'd1);
      chk("debug_shift_cnt", n_sh, 64'd10);
      chk("debug_update_cnt", n_upd, 64'd1);

      ir_scan(4, 16'b1111);
      dr_scan(8, 64'b11001101, 64'd0);
      v = obs_vec();
      chk("bypass_1111", v[7:0], 64'h9A);
      ir_scan(4, 16'b0111);
      dr_scan(8, 64'b11001101, 64'd0);
      v = obs_vec();
      chk("bypass_0111", v[7:0], 64'h9A);

      ir_scan(6, 16'b100000);
      chk("ir_overlength_debug", 64'(debug_select_o), 64'd1);

      goto_rti();
      n_upd = 0;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      pulse_reset();
      chk("reset_mid_ir_tlr", 64'(test_logic_reset_o), 64'd1);
      chk("reset_mid_ir_debug_sel", 64'(debug_select_o), 64'd0);
      tick(1'b0, 1'b0, 1'b0);
      chk("reset_no_update", n_upd, 64'd0);
      dr_scan(32, 64'd0, 64'd0);
      v = obs_vec();
      chk("idcode_after_abort", v[31:0], 64'h249511C3);

      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 3))
            0: op = 4'b0010;
            1: op = 4'b1000;
            2: op = 4'b1111;
            default: op = 4'($urandom);
         endcase
         ir_scan($urandom_range(4, 7), {12'($urandom), op} << 0);
         dr_scan($urandom_range(1, 40), {$urandom, $urandom}, {$urandom, $urandom});
         repeat ($urandom_range(0, 12)) tick(1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 7) == 0) pulse_reset();
         goto_rti();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
